gate_rr_arbiter: RTL and testbench
==================================

# gate_rr_arbiter

Shares one registered bitwise logic unit (AND, OR, NOT a, NOT b) between `NREQ` requesters. The block arbitrates round-robin, latches the winner's opcode and operands, and computes the result in one cycle. It then holds the tagged result on a valid/ready response port until the response is accepted. It sits between the gate-level datapath and any set of agents that want logic operations without each instantiating its own gates.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `WIDTH`, 8, operand/result width in bits
- `IDW`, 2, requester-id width, equal to clog2(`NREQ`)

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `req`  in  `NREQ`  request vector, bit i belongs to requester i
- `op`  in  2*`NREQ`  packed opcodes, bits [2i+1:2i] belong to requester i
- `a`  in  `WIDTH`*`NREQ`  packed operand a, slice i belongs to requester i
- `b`  in  `WIDTH`*`NREQ`  packed operand b, slice i belongs to requester i
- `gnt`  out  `NREQ`  one-hot, one-cycle grant pulse
- `busy`  out  1  high in every state except IDLE
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer accepts result
- `rsp_id`  out  `IDW`  index of the requester that owns the result
- `rsp_data`  out  `WIDTH`  result

## Operation
- Opcodes:
  - 00: a & b
  - 01: a | b
  - 10: ~a
  - 11: ~b
- NOT ignores the unused operand. Result is exactly `WIDTH` bits; there is no carry or extension.
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If `req` != 0, pick the winner. The winner is the first set bit scanning upward from `ptr` and wrapping at `NREQ`-1 back to 0.
  - Register `gnt` = one-hot(winner). Latch the winner's op, a and b into internal registers. Set `ptr` <= (winner+1) mod `NREQ`. Go to EXEC.
  - If `req` == 0, stay in IDLE and hold `ptr`.
- EXEC:
  - Clear `gnt`.
  - Register `rsp_data` = f(op, a, b) from the latched values, `rsp_id` = winner, `rsp_valid` = 1.
  - Go to RESP.
- RESP:
  - Hold `rsp_valid`, `rsp_id` and `rsp_data` stable.
  - On the edge where `rsp_valid` & `rsp_ready`, clear `rsp_valid` and go to IDLE.
  - New requests are not sampled in EXEC or RESP.
- Requester contract:
  - Hold `req`, `op`, `a` and `b` stable until `gnt[i]` is seen.
  - Operand changes after the grant edge do not affect the result.
  - A `req` dropped before the grant is never serviced and leaves no trace.
- `ptr` resets to 0. It advances only on a grant.
- `rsp_ready` asserted while `rsp_valid` is 0 has no effect.

## Timing
- Reset values, applied immediately on `rst_n` low regardless of `clk`:
  - `gnt` = 0, `busy` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0
  - `ptr` = 0, state = IDLE, latched operands = 0
- Reset mid-operation aborts the transaction: no response is produced and `ptr` returns to 0.
- Grant latency: `req` sampled high at edge k in IDLE -> `gnt` high for exactly the cycle between edges k and k+1.
- Response latency: `rsp_valid` rises at edge k+1.
- If `rsp_ready` is already high when `rsp_valid` rises, the handshake occurs at edge k+2 and the FSM is back in IDLE after edge k+2.
- A new request can be sampled at edge k+3, so minimum service interval is 3 cycles.
- `busy` is the registered equivalent of state != IDLE. It is high from edge k through the handshake edge.
- Outputs are all registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert `rst_n`=0 mid-RESP with `rsp_valid`=1 -> all outputs 0 immediately. After release, `req`=0001 is granted to requester 0.
- Single op, `rsp_ready` tied high: requester 2 issues op=00, a=8'hF0, b=8'h3C -> `gnt`=0100 for one cycle. Next cycle `rsp_valid`=1, `rsp_id`=2, `rsp_data`=8'h30.
- All opcodes, requester 1, a=8'hA5, b=8'h0F:
  - op=00 -> 8'h05
  - op=01 -> 8'hAF
  - op=10 -> 8'h5A
  - op=11 -> 8'hF0
- Round-robin fairness: `req`=1111 held continuously -> grants 0, 1, 2, 3, 0 in order, every 3 cycles.
- Round-robin wrap: with `ptr`=3 and `req`=0011 -> grant goes to 0, then 1.
- Backpressure: `rsp_ready`=0 for 5 cycles after `rsp_valid` rises -> `rsp_valid`, `rsp_id` and `rsp_data` stay constant.
  - Requester operands changed during the stall -> the result is unchanged.
  - `gnt` stays 0 throughout the stall.
  - After `rsp_ready`=1, the next grant is sampled one cycle later.

Source files
------------

// File: rtl/gate_rr_arbiter.sv
// gate_rr_arbiter: shares one registered bitwise logic unit between NREQ requesters.
// A round-robin pick captures the winner's opcode and operands. The result is computed
// one cycle later and held on a valid/ready response port until it is accepted.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req        request vector, bit i = requester i
//   op         packed 2-bit opcodes, [2i+1:2i] = requester i
//                (00 and, 01 or, 10 not a, 11 not b)
//   a, b       packed operands, slice i = requester i
//   gnt        one-hot grant, pulses for one cycle
//   busy       high while a transaction is in flight
//   rsp_valid  result available
//   rsp_ready  consumer accepts the result
//   rsp_id     requester that owns the result
//   rsp_data   result
module gate_rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     op,
  input  logic [WIDTH*NREQ-1:0] a,
  input  logic [WIDTH*NREQ-1:0] b,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   win_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic             win_found;
  logic [IDW-1:0]   win_id;
  logic [IDW-1:0]   ptr_next;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] op_result;

  // Round-robin pick: scan offsets from the highest down so the smallest offset
  // from ptr is the last assignment and therefore wins.
  always_comb begin
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    win_found = |req;
    win_id    = '0;
    sum       = '0;
    idx       = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      sum = {1'b0, ptr_q} + (IDW + 1)'(i);
      if (sum >= (IDW + 1)'(NREQ)) begin
        sum = sum - (IDW + 1)'(NREQ);
      end
      idx = sum[IDW-1:0];
      if (req[idx]) begin
        win_id = idx;
      end
    end
  end

  assign ptr_next = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;

  // Operand mux for the winning requester.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (IDW'(i) == win_id) begin
        sel_op = op[2*i +: 2];
        sel_a  = a[WIDTH*i +: WIDTH];
        sel_b  = b[WIDTH*i +: WIDTH];
      end
    end
  end

  always_comb begin
    op_result = '0;
    case (op_q)
      2'b00:   op_result = a_q & b_q;
      2'b01:   op_result = a_q | b_q;
      2'b10:   op_result = ~a_q;
      default: op_result = ~b_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      win_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (win_found) begin
            gnt     <= NREQ'(1) << win_id;
            win_q   <= win_id;
            op_q    <= sel_op;
            a_q     <= sel_a;
            b_q     <= sel_b;
            ptr_q   <= ptr_next;
            busy    <= 1'b1;
            state_q <= StExec;
          end
        end
        StExec: begin
          gnt       <= '0;
          rsp_data  <= op_result;
          rsp_id    <= win_q;
          rsp_valid <= 1'b1;
          state_q   <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_rr_arbiter.sv
// Self-checking bench for gate_rr_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level round-robin model.
module tb_gate_rr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     op;
  logic [WIDTH*NREQ-1:0] a;
  logic [WIDTH*NREQ-1:0] b;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;

  int n_tests = 0;
  int n_fail  = 0;
  int m_ptr   = 0;

  gate_rr_arbiter #(
    .NREQ (NREQ),
    .WIDTH(WIDTH),
    .IDW  (IDW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .op       (op),
    .a        (a),
    .b        (b),
    .gnt      (gnt),
    .busy     (busy),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [1:0] o, input logic [7:0] x,
                                        input logic [7:0] y);
    case (o)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return ~x;
      default: return ~y;
    endcase
  endfunction

  // One full transaction starting from IDLE, 1 ns after an active edge.
  task automatic txn(input logic [3:0] rq, input logic [7:0] ops, input logic [31:0] aa,
                     input logic [31:0] bb, input int stall, input bit scramble);
    int         w;
    logic [7:0] exp;
    w = -1;
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = (m_ptr + i) % NREQ;
      if (w < 0 && rq[k]) w = k;
    end
    exp   = ref_op(ops[2*w +: 2], aa[8*w +: 8], bb[8*w +: 8]);
    m_ptr = (w + 1) % NREQ;

    req = rq; op = ops; a = aa; b = bb;
    rsp_ready = (stall == 0);
    @(posedge clk); #1;
    check("gnt_onehot", gnt, 32'(1 << w));
    check("busy_at_grant", busy, 1);
    check("valid_at_grant", rsp_valid, 0);
    if (scramble) begin a = $urandom; b = $urandom; op = 8'($urandom); end
    @(posedge clk); #1;
    check("gnt_cleared", gnt, 0);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_id", rsp_id, w);
    check("rsp_data", rsp_data, exp);
    check("busy_exec", busy, 1);
    for (int s = 0; s < stall; s++) begin
      if (scramble) begin a = $urandom; b = $urandom; op = 8'($urandom); end
      @(posedge clk); #1;
      check("stall_valid", rsp_valid, 1);
      check("stall_id", rsp_id, w);
      check("stall_data", rsp_data, exp);
      check("stall_gnt", gnt, 0);
      check("stall_busy", busy, 1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("hs_valid", rsp_valid, 0);
    check("hs_busy", busy, 0);
    check("hs_gnt", gnt, 0);
    rsp_ready = 1'($urandom);
  endtask

  task automatic idle(input int n);
    req = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle_gnt", gnt, 0);
      check("idle_busy", busy, 0);
      check("idle_valid", rsp_valid, 0);
    end
  endtask

  initial begin
    rst_n = 1'b1; req = '0; op = '0; a = '0; b = '0; rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", rsp_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Single op from requester 2: F0 & 3C = 30.
    txn(4'b0100, 8'h00, 32'h00F0_0000, 32'h003C_0000, 0, 1'b0);

    // Every opcode from requester 1.
    for (int o = 0; o < 4; o++) begin
      txn(4'b0010, 8'(o << 2), 32'h0000_A500, 32'h0000_0F00, 0, 1'b1);
    end

    // Reset in the middle of RESP: requester 1 result pending, then abort.
    req = 4'b0010; op = 8'b0000_0100; a = 32'h0000_A500; b = 32'h0000_0F00;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_valid", rsp_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_gnt", gnt, 0);
    check("midrst_busy", busy, 0);
    check("midrst_valid", rsp_valid, 0);
    check("midrst_id", rsp_id, 0);
    check("midrst_data", rsp_data, 0);
    m_ptr = 0;
    req = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    txn(4'b0001, 8'h00, $urandom, $urandom, 0, 1'b1);

    // Fairness with all requesters pending back to back.
    for (int i = 0; i < 5; i++) begin
      txn(4'b1111, 8'($urandom), $urandom, $urandom, 0, 1'b1);
    end

    // Wrap: drive ptr to 3, then 0011 must go to 0 then 1.
    txn(4'b0100, 8'($urandom), $urandom, $urandom, 0, 1'b1);
    txn(4'b0011, 8'($urandom), $urandom, $urandom, 0, 1'b1);
    txn(4'b0011, 8'($urandom), $urandom, $urandom, 0, 1'b1);

    // Backpressure with operand churn, then an immediate follow-up request.
    txn(4'b1010, 8'($urandom), $urandom, $urandom, 5, 1'b1);
    txn(4'b1111, 8'($urandom), $urandom, $urandom, 0, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      txn(4'($urandom_range(1, 15)), 8'($urandom), $urandom, $urandom,
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, 1'b1);
      if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
